// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: CP0 responder with priority interrupt arbitration.
// Handles nesting, the EPC stack, and eret/mfc0/mtc0 requests.
// Ports: clk, rst (sync, active-high), irq_in, take_ok, pc_next,
//   mtc0, mfc0, eret, cp0_sel, wdata -> rdata, int_take,
//   int_vector, eret_pc, in_service.
// Option: define CP0_IRQ_SYNC_EN to add a 2-flop irq_in synchronizer.
module cp0_irq_ctrl #(
    parameter int          NUM_IRQ      = 3,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010,
    parameter int          GUARD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               take_ok,
    input  logic [31:0]        pc_next,
    input  logic               mtc0,
    input  logic               mfc0,
    input  logic               eret,
    input  logic [4:0]         cp0_sel,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               int_take,
    output logic [31:0]        int_vector,
    output logic [31:0]        eret_pc,
    output logic [NUM_IRQ-1:0] in_service
);
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int DW = $clog2(NUM_IRQ + 1);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

    typedef enum logic {S_RUN, S_GUARD} state_t;

    state_t             r_state;
    logic [GW-1:0]      r_guard;
    logic [NUM_IRQ:0]   r_status;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_in_service;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [31:0]        r_epc [NUM_IRQ];
    logic [DW-1:0]      r_depth;

    logic [NUM_IRQ-1:0] w_irq;
    logic [NUM_IRQ-1:0] w_rise;
    logic               w_cand_valid;
    logic [IW-1:0]      w_cand_idx;
    logic [IW-1:0]      w_isr_top;
    logic               w_eligible;
    logic               w_take;
    logic               w_pop;
    logic [DW-1:0]      w_top_idx;
    logic [31:0]        w_top_val;
    logic [NUM_IRQ-1:0] w_pend_clr;
    logic               w_wr_status;
    logic               w_wr_cause;
    logic               w_wr_epc;

`ifdef CP0_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_irq = r_sync2;
`else
    assign w_irq = irq_in;
`endif

    assign w_rise = w_irq & ~r_irq_prev;

    // Ascending scans: the last hit is the highest index.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_idx   = '0;
        w_isr_top    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (r_pending[i] && r_status[i+1]) begin
                w_cand_valid = 1'b1;
                w_cand_idx   = IW'(i);
            end
            if (r_in_service[i]) begin
                w_isr_top = IW'(i);
            end
        end
    end

    assign w_eligible = r_status[0] && w_cand_valid &&
                        (!(|r_in_service) || (w_cand_idx > w_isr_top));

    // eret has priority; the take is re-evaluated next cycle.
    assign w_take = (r_state == S_RUN) && w_eligible && take_ok && !eret;
    assign w_pop  = eret && (r_depth != '0);

    assign w_top_idx = r_depth - 1'b1;
    assign w_top_val = (r_depth != '0) ? r_epc[w_top_idx] : 32'h0;

    assign w_wr_status = mtc0 && (cp0_sel == 5'd12);
    assign w_wr_cause  = mtc0 && (cp0_sel == 5'd13);
    assign w_wr_epc    = mtc0 && (cp0_sel == 5'd14) && (r_depth != '0);

    always_comb begin
        w_pend_clr = '0;
        if (w_wr_cause) w_pend_clr = w_pend_clr | wdata[NUM_IRQ-1:0];
        if (w_take)     w_pend_clr = w_pend_clr | (NUM_IRQ'(1) << w_cand_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_guard      <= '0;
            r_status     <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_irq_prev   <= '0;
            r_depth      <= '0;
            for (int i = 0; i < NUM_IRQ; i++) r_epc[i] <= 32'h0;
        end else begin
            r_irq_prev <= w_irq;
            // New edges win over W1C or take clears.
            r_pending  <= (r_pending & ~w_pend_clr) | w_rise;
            if (w_wr_status) r_status <= wdata[NUM_IRQ:0];
            if (w_wr_epc)    r_epc[w_top_idx] <= wdata;

            if (w_take) begin
                r_in_service <= r_in_service | (NUM_IRQ'(1) << w_cand_idx);
                if (r_depth < DW'(NUM_IRQ)) begin
                    r_epc[r_depth] <= pc_next;
                    r_depth        <= r_depth + 1'b1;
                end
            end else if (w_pop) begin
                r_in_service <= r_in_service & ~(NUM_IRQ'(1) << w_isr_top);
                r_depth      <= r_depth - 1'b1;
            end

            case (r_state)
                S_RUN: begin
                    if (w_take) begin
                        r_state <= S_GUARD;
                        r_guard <= GW'(GUARD_CYCLES);
                    end
                end
                S_GUARD: begin
                    if (r_guard <= GW'(1)) begin
                        r_state <= S_RUN;
                        r_guard <= '0;
                    end else begin
                        r_guard <= r_guard - 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (mfc0 && !rst) begin
            case (cp0_sel)
                5'd12:   rdata = 32'(r_status);
                5'd13:   rdata = 32'(r_pending);
                5'd14:   rdata = w_top_val;
                default: rdata = 32'h0;
            endcase
        end
    end

    assign int_take   = w_take && !rst;
    assign int_vector = (!rst && r_state == S_RUN && w_eligible) ?
                        VEC_BASE + 32'(w_cand_idx) * VEC_STRIDE : 32'h0;
    assign eret_pc    = (!rst && eret) ? w_top_val : 32'h0;
    assign in_service = rst ? '0 : r_in_service;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// tb_cp0_irq_ctrl: directed checks for cp0_irq_ctrl.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_cp0_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        take_ok;
    logic [31:0] pc_next;
    logic        mtc0;
    logic        mfc0;
    logic        eret;
    logic [4:0]  cp0_sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        int_take;
    logic [31:0] int_vector;
    logic [31:0] eret_pc;
    logic [2:0]  in_service;

    int n_checks = 0;
    int n_fail   = 0;

    cp0_irq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .take_ok    (take_ok),
        .pc_next    (pc_next),
        .mtc0       (mtc0),
        .mfc0       (mfc0),
        .eret       (eret),
        .cp0_sel    (cp0_sel),
        .wdata      (wdata),
        .rdata      (rdata),
        .int_take   (int_take),
        .int_vector (int_vector),
        .eret_pc    (eret_pc),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] sel, output logic [31:0] d);
        mfc0    = 1'b1;
        cp0_sel = sel;
        #1;
        d       = rdata;
        mfc0    = 1'b0;
    endtask

    task automatic wr(input logic [4:0] sel, input logic [31:0] d);
        mtc0    = 1'b1;
        cp0_sel = sel;
        wdata   = d;
        step();
        mtc0    = 1'b0;
    endtask

    // Leaves the bench in the cycle where int_take is high (ok=1).
    task automatic wait_take(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            #1;
            if (int_take) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic pulse(input logic [2:0] v);
        irq_in = v;
        step();
        irq_in = 3'b000;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    logic [31:0] d;
    logic        ok;

    initial begin
        rst = 1'b1; irq_in = '0; take_ok = 1'b0; pc_next = '0;
        mtc0 = 1'b0; mfc0 = 1'b0; eret = 1'b0; cp0_sel = '0; wdata = '0;
        step(); step(); step();
        #1;
        check("rst_take", {31'b0, int_take}, 32'h0);
        check("rst_isr", {29'b0, in_service}, 32'h0);
        rd(5'd12, d); check("rst_status_rd", d, 32'h0);
        rst = 1'b0;
        step();
        rd(5'd12, d); check("reset_status", d, 32'h0);
        rd(5'd13, d); check("reset_cause", d, 32'h0);
        rd(5'd14, d); check("reset_epc", d, 32'h0);

        // 1: single take of source 0
        wr(5'd12, 32'hF);
        rd(5'd12, d); check("status_wr", d, 32'hF);
        take_ok = 1'b1; pc_next = 32'h40;
        pulse(3'b001);
        wait_take(8, ok);
        check("t1_take", {31'b0, ok}, 32'h1);
        check("t1_vec", int_vector, 32'h100);
        step(); #1;
        check("t1_pulse1", {31'b0, int_take}, 32'h0);
        check("t1_isr", {29'b0, in_service}, 32'h1);
        rd(5'd14, d); check("t1_epc", d, 32'h40);

        // 2: nested take of source 2, then two erets
        pc_next = 32'h105;
        pulse(3'b100);
        wait_take(8, ok);
        check("t2_take", {31'b0, ok}, 32'h1);
        check("t2_vec", int_vector, 32'h120);
        step();
        check("t2_isr", {29'b0, in_service}, 32'h5);
        eret = 1'b1; #1;
        check("t2_eretpc1", eret_pc, 32'h105);
        step(); eret = 1'b0;
        check("t2_isr1", {29'b0, in_service}, 32'h1);
        eret = 1'b1; #1;
        check("t2_eretpc0", eret_pc, 32'h40);
        step(); eret = 1'b0;
        check("t2_isr0", {29'b0, in_service}, 32'h0);

        // 3: lower priority held pending during handler 1
        pc_next = 32'h200;
        pulse(3'b010);
        wait_take(8, ok);
        check("t3_take1", {31'b0, ok}, 32'h1);
        check("t3_vec1", int_vector, 32'h110);
        step(); step(); step();
        pulse(3'b001);
        for (int i = 0; i < 4; i++) begin
            #1; check("t3_blocked", {31'b0, int_take}, 32'h0);
            step();
        end
        rd(5'd13, d); check("t3_pend", d, 32'h1);
        do_eret();
        wait_take(2, ok);
        check("t3_take0", {31'b0, ok}, 32'h1);
        check("t3_vec0", int_vector, 32'h100);
        step();
        check("t3_isr", {29'b0, in_service}, 32'h1);
        do_eret();
        step(); step();

        // 4: take_ok held low
        take_ok = 1'b0;
        pulse(3'b010);
        for (int i = 0; i < 5; i++) begin
            #1; check("t4_notake", {31'b0, int_take}, 32'h0);
            step();
        end
        rd(5'd13, d); check("t4_cause_pre", d, 32'h2);
        take_ok = 1'b1; #1;
        check("t4_take", {31'b0, int_take}, 32'h1);
        check("t4_vec", int_vector, 32'h110);
        step();
        rd(5'd13, d); check("t4_cause_post", d, 32'h0);
        check("t4_isr", {29'b0, in_service}, 32'h2);
        do_eret();
        step(); step();

        // 5: eret and eligible take in the same cycle
        pc_next = 32'h300;
        pulse(3'b001);
        wait_take(8, ok);
        check("t5_take0", {31'b0, ok}, 32'h1);
        step();
        take_ok = 1'b0;
        step(); step(); step();
        pc_next = 32'h340;
        pulse(3'b100);
        step(); step(); step(); step();
        eret = 1'b1; take_ok = 1'b1; #1;
        check("t5_eret_wins", {31'b0, int_take}, 32'h0);
        check("t5_eretpc", eret_pc, 32'h300);
        step(); eret = 1'b0; #1;
        check("t5_popped", {29'b0, in_service}, 32'h0);
        check("t5_take_late", {31'b0, int_take}, 32'h1);
        check("t5_vec", int_vector, 32'h120);
        step();
        check("t5_isr", {29'b0, in_service}, 32'h4);
        do_eret();
        step(); step();

        // 6: W1C on CAUSE and eret with empty stack
        take_ok = 1'b0;
        pulse(3'b110);
        step(); step(); step(); step();
        rd(5'd13, d); check("t6_pend", d, 32'h6);
        wr(5'd13, 32'h4);
        rd(5'd13, d); check("t6_w1c", d, 32'h2);
        eret = 1'b1; #1;
        check("t6_eretpc0", eret_pc, 32'h0);
        step(); eret = 1'b0;
        check("t6_isr", {29'b0, in_service}, 32'h0);
        rd(5'd13, d); check("t6_cause_kept", d, 32'h2);
        wr(5'd14, 32'hDEAD);
        rd(5'd14, d); check("t6_epc_drop", d, 32'h0);

        // reset while in a handler
        take_ok = 1'b1; pc_next = 32'h500;
        wait_take(4, ok);
        check("t7_take", {31'b0, ok}, 32'h1);
        step();
        check("t7_isr", {29'b0, in_service}, 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("t7_isr_rst", {29'b0, in_service}, 32'h0);
        rd(5'd14, d); check("t7_epc_rst", d, 32'h0);
        rd(5'd12, d); check("t7_status_rst", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cp0_irq_ctrl.md
Name: cp0_irq_ctrl

Overview:
Coprocessor-0 responder for the multi-interrupt pipelined CPU. It services the eret/mfc0/mtc0 requests that the decode stage raises. It latches external interrupt requests, arbitrates them by priority with nesting, and tells the pipeline when to flush and jump to a handler vector. It also keeps the nested EPC stack that eret returns through.

Parameters:
NUM_IRQ, 3, number of interrupt sources. Source index i has priority i; the highest index wins.
VEC_BASE, 32'h0000_0100, handler vector of source 0 (word address).
VEC_STRIDE, 32'h0000_0010, vector spacing. Vector(i) = VEC_BASE + i*VEC_STRIDE.
GUARD_CYCLES, 2, cycles after a take during which no further take is allowed.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
irq_in  in  NUM_IRQ  raw interrupt request levels; a rising edge requests service
take_ok  in  1  pipeline is at an interrupt-safe point (no stall, no branch/jump in flight)
pc_next  in  32  word address of the oldest uncommitted instruction; pushed as EPC on a take
mtc0  in  1  write cp0_sel with wdata this cycle
mfc0  in  1  read request; rdata is valid this cycle
eret  in  1  return from the current handler
cp0_sel  in  5  CP0 register select: 12 STATUS, 13 CAUSE, 14 EPC
wdata  in  32  mtc0 write data
rdata  out  32  mfc0 read data
int_take  out  1  single-cycle flush-and-redirect request
int_vector  out  32  redirect target, valid while int_take is high
eret_pc  out  32  return target, valid while eret is high
in_service  out  NUM_IRQ  one-hot-per-level bitmap of active handlers

Behaviour:
- Reset state: STATUS = 0, so IE = 0 and all sources are masked. Pending = 0, in_service = 0, EPC stack empty (depth 0, entries 0), irq_prev = 0, FSM = RUN, guard counter = 0. All outputs read 0 during and after reset.
- STATUS register:
  - bit0 is IE (global enable).
  - bits[NUM_IRQ:1] are per-source enables.
  - Other bits read 0.
- CAUSE register:
  - bits[NUM_IRQ-1:0] are the pending bits. They are read-only through the set path.
  - mtc0 to CAUSE is write-1-to-clear.
- EPC register: reads and writes the top stack entry. When depth = 0, reads return 0 and writes are dropped.
- Edge capture: pending[i] is set when irq_in[i] & ~irq_prev[i]. irq_prev <= irq_in every cycle. If a set and a clear of the same bit (W1C or take) land in the same cycle, the set wins.
- Candidate selection:
  - The candidate is the highest i with pending[i] & STATUS[i+1].
  - It is eligible only if IE = 1 and i > the highest set bit of in_service (or in_service = 0).
- FSM RUN:
  - int_take = eligible & take_ok & ~eret. This is combinational, same cycle.
  - On take, at the clock edge: push pc_next, set in_service[i], clear pending[i], load the guard counter with GUARD_CYCLES, go to GUARD.
  - int_vector = Vector(candidate) whenever an eligible candidate exists, else 0.
- FSM GUARD:
  - int_take = 0.
  - The counter decrements each cycle; on reaching 1 the FSM returns to RUN.
  - eret and mtc0/mfc0 are still serviced in GUARD.
- eret:
  - eret_pc = top of stack, combinational.
  - At the edge: pop, and clear the highest set bit of in_service.
  - With depth = 0, eret_pc = 0 and there is no state change.
  - If eret and an eligible take coincide, eret wins and the take is re-evaluated the next cycle.
- Stack depth: at most NUM_IRQ, because each level is active at most once. Overflow is structurally impossible; a push at full depth is dropped.
- mfc0:
  - rdata = the selected register when mfc0 = 1, else 0.
  - Unknown cp0_sel reads 0.
  - A read concurrent with an mtc0 returns the old value.
- mtc0 vs. take: an mtc0 to STATUS clearing IE takes effect from the next cycle. A take in the same cycle still proceeds.
- Reset mid-handler: everything returns to reset values. The stack contents are discarded.

Optional Feature:
Macro CP0_IRQ_SYNC_EN.
- Defined: each irq_in passes through a 2-flop synchronizer before edge capture. The earliest int_take is then 3 cycles after the irq_in rise.
- Undefined: irq_in is edge-detected directly. pending becomes visible 1 cycle after the rise, and the earliest int_take is in that cycle.
- Reset clears the synchronizer flops.

Test Plan:
1. Reset, then mtc0 STATUS = 32'hF; pulse irq_in = 3'b001 with take_ok = 1 and pc_next = 32'h40 -> int_take pulses for 1 cycle with int_vector = 32'h100, EPC reads 32'h40, in_service = 3'b001.
2. In the handler of source 0, pulse irq_in[2] with pc_next = 32'h105 -> nested take with int_vector = 32'h120. eret gives eret_pc = 32'h105 and in_service = 3'b001; a second eret gives eret_pc = 32'h40 and in_service = 0.
3. In the handler of source 1, pulse irq_in[0] -> no take, pending[0] = 1. After eret, the take of source 0 occurs on the next RUN cycle with take_ok = 1.
4. Pulse irq_in[1] while take_ok = 0 for 5 cycles -> no int_take. int_take asserts in the first cycle take_ok = 1. CAUSE reads 32'h2 before the take and 0 after.
5. Assert eret and an eligible candidate in the same cycle -> int_take = 0 that cycle, the pop occurs, and the take happens one cycle later.
6. mtc0 CAUSE = 32'h4 with pending = 3'b110 -> pending becomes 3'b010. Issue eret with depth 0 -> eret_pc = 0 and no state change.
